// File: rtl/powlib_busmem_resp_if.sv
// Request/response bus bundle for the memory responder: request side (wr*) and response side (rd*).
// Pure wiring, no latency.
// Valid/ready on both sides. The slave modport is the responder and the master modport is the requester.
// Ports: wrdata/wraddr/wrvld -> responder, wrrdy <- responder;
//        rddata/rdaddr/rdvld <- responder, rdrdy -> responder.
interface powlib_busmem_resp_if #(
    parameter int B_AW  = 4,
    parameter int B_BPD = 4
);
    localparam int B_DW = 1 + B_BPD + 8 * B_BPD;

    logic [B_DW-1:0] wrdata;
    logic [B_AW-1:0] wraddr;
    logic            wrvld;
    logic            wrrdy;
    logic [B_DW-1:0] rddata;
    logic [B_AW-1:0] rdaddr;
    logic            rdvld;
    logic            rdrdy;

    modport master (
        output wrdata, wraddr, wrvld, rdrdy,
        input  wrrdy, rddata, rdaddr, rdvld
    );

    modport slave (
        input  wrdata, wraddr, wrvld, rdrdy,
        output wrrdy, rddata, rdaddr, rdvld
    );
endinterface

// File: rtl/powlib_busmem_resp.sv
// Bus memory responder. Byte-enabled writes go into a 2**B_AW word register memory, and each read returns one response word.
// A write commits on its accept edge. A read accepted at edge N gives rdvld after edge N+1, and the next request can be accepted at N+3.
// wrrdy is low while a read is in flight, and it stays low for as long as rdrdy holds the response (full backpressure).
// Ports: clk, rst (async, active-low), bus (slave modport of powlib_busmem_resp_if).
//   Word format: {op(1=write), be[B_BPD-1:0], data[8*B_BPD-1:0]}.
module powlib_busmem_resp #(
    parameter int B_AW  = 4,
    parameter int B_BPD = 4,
    parameter bit EAR   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    powlib_busmem_resp_if.slave   bus
);
    localparam int B_DW  = 1 + B_BPD + 8 * B_BPD;
    localparam int DW    = 8 * B_BPD;
    localparam int DEPTH = 1 << B_AW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [B_AW-1:0] req_addr;
    logic [B_DW-1:0] rddata;
    logic [B_AW-1:0] rdaddr;
    logic            rdvld;
    logic [DW-1:0]   mem [0:DEPTH-1];

    logic              req_op;
    logic [B_BPD-1:0]  req_be;
    logic [DW-1:0]     req_data;
    logic              wrrdy;
    logic              req_fire;

    assign req_op   = bus.wrdata[B_DW-1];
    assign req_be   = bus.wrdata[DW +: B_BPD];
    assign req_data = bus.wrdata[DW-1:0];

    // Ready comes only from registered state and reset, so the wrvld/rdrdy side has no combinational loop.
    assign wrrdy    = (state == IDLE) && rst;
    assign req_fire = bus.wrvld && wrrdy;

    assign bus.wrrdy  = wrrdy;
    assign bus.rddata = rddata;
    assign bus.rdaddr = rdaddr;
    assign bus.rdvld  = rdvld;

    // Control and response registers. Reset drops any in-flight response at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rddata <= '0;
            rdaddr <= '0;
            rdvld  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire && !req_op) begin
                        state <= RD;
                    end
                end
                RD: begin
                    rddata <= {1'b0, {B_BPD{1'b1}}, mem[req_addr]};
                    rdaddr <= req_addr;
                    rdvld  <= 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    if (bus.rdrdy) begin
                        rdvld <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The read address register is always loaded before it is used, so it only needs a reset when EAR asks for one.
    generate
        if (EAR) begin : g_addr_arst
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    req_addr <= '0;
                end else if (req_fire && !req_op) begin
                    req_addr <= bus.wraddr;
                end
            end
        end else begin : g_addr_nrst
            always_ff @(posedge clk) begin
                if (req_fire && !req_op) begin
                    req_addr <= bus.wraddr;
                end
            end
        end
    endgenerate

    // The memory is not reset. A write with be=0 is accepted but changes nothing.
    always_ff @(posedge clk) begin
        if (req_fire && req_op) begin
            for (int b = 0; b < B_BPD; b++) begin
                if (req_be[b]) begin
                    mem[bus.wraddr][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_powlib_busmem_resp.sv
module tb_powlib_busmem_resp;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;
    int   last_wait;
    int   last_acc;
    logic [31:0] model [0:15];

    powlib_busmem_resp_if #(.B_AW(4), .B_BPD(4)) bus ();

    powlib_busmem_resp #(.B_AW(4), .B_BPD(4), .EAR(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request at a negedge and returns at the negedge that follows the accepting posedge.
    task automatic issue(input logic op, input logic [3:0] addr, input logic [3:0] be, input logic [31:0] data);
        bus.wrdata = {op, be, data};
        bus.wraddr = addr;
        bus.wrvld  = 1'b1;
        last_wait  = 0;
        while (!bus.wrrdy && last_wait < 50) begin
            @(negedge clk);
            last_wait++;
        end
        if (!bus.wrrdy) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
            last_acc = cyc;
        end
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] data);
        issue(1'b1, addr, be, data);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model[addr][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic do_read(input logic [3:0] addr, input int hold);
        logic [36:0] exp;
        issue(1'b0, addr, 4'($urandom), $urandom);
        bus.wrvld  = 1'b0;
        bus.rdrdy  = (hold == 0);
        exp = {1'b0, 4'hF, model[addr]};
        check("rd_vld_after_1_edge", 64'(bus.rdvld), 64'd0);
        @(negedge clk);
        check("rd_vld_after_2_edges", 64'(bus.rdvld), 64'd1);
        check("rd_data", 64'(bus.rddata), 64'(exp));
        check("rd_addr", 64'(bus.rdaddr), 64'(addr));
        check("rd_wrrdy_busy", 64'(bus.wrrdy), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_vld", 64'(bus.rdvld), 64'd1);
            check("bp_data", 64'(bus.rddata), 64'(exp));
            check("bp_addr", 64'(bus.rdaddr), 64'(addr));
            check("bp_wrrdy", 64'(bus.wrrdy), 64'd0);
        end
        bus.rdrdy = 1'b1;
        @(negedge clk);
        check("rd_vld_done", 64'(bus.rdvld), 64'd0);
        check("rd_wrrdy_back", 64'(bus.wrrdy), 64'd1);
    endtask

    initial begin
        int prev_acc;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b0;
        bus.wrvld  = 1'b0;
        bus.wrdata = '0;
        bus.wraddr = '0;
        bus.rdrdy  = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // Reset state
        #1;
        check("rst_rdvld", 64'(bus.rdvld), 64'd0);
        check("rst_wrrdy", 64'(bus.wrrdy), 64'd0);
        check("rst_rddata", 64'(bus.rddata), 64'd0);
        check("rst_rdaddr", 64'(bus.rdaddr), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_wrrdy_held", 64'(bus.wrrdy), 64'd0);
        rst = 1'b1;
        #1;
        check("release_wrrdy", 64'(bus.wrrdy), 64'd1);
        @(negedge clk);

        // Basic write/read
        do_write(4'd3, 4'hF, 32'hDEADBEEF);
        do_read(4'd3, 0);

        // Partial write, then a write with be=0
        do_write(4'd5, 4'hF, 32'h11223344);
        do_write(4'd5, 4'h5, 32'hAABBCCDD);
        bus.wrvld = 1'b0;
        do_read(4'd5, 0);
        check("partial_const", 64'(model[5]), 64'h11BB33DD);
        do_write(4'd5, 4'h0, 32'hFFFFFFFF);
        bus.wrvld = 1'b0;
        do_read(4'd5, 0);

        // Backpressure
        do_read(4'd3, 10);

        // Streaming writes, then streaming reads
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 4'hF, 32'(i) * 32'h01010101);
            check("stream_wr_nowait", 64'(last_wait), 64'd0);
            if (i > 0) check("stream_wr_rate", 64'(last_acc - prev_acc), 64'd1);
            prev_acc = last_acc;
        end
        bus.wrvld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 0);
            check("stream_rd_nowait", 64'(last_wait), 64'd0);
            if (i > 0) check("stream_rd_rate", 64'(last_acc - prev_acc), 64'd3);
            prev_acc = last_acc;
        end

        // Read immediately after write
        do_write(4'd7, 4'hF, 32'hCAFEF00D);
        prev_acc = last_acc;
        do_read(4'd7, 0);
        check("raw_back_to_back", 64'(last_acc - prev_acc), 64'd1);

        // Randomized mix against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_write(4'($urandom), 4'($urandom), $urandom);
                bus.wrvld = 1'b0;
            end else begin
                do_read(4'($urandom), int'($urandom_range(3, 0)));
            end
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end

        // Asynchronous reset while the responder holds a response
        issue(1'b0, 4'd3, 4'h0, 32'h0);
        bus.wrvld = 1'b0;
        bus.rdrdy = 1'b0;
        @(negedge clk);
        check("arst_pre_vld", 64'(bus.rdvld), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_rdvld", 64'(bus.rdvld), 64'd0);
        check("arst_wrrdy", 64'(bus.wrrdy), 64'd0);
        check("arst_rddata", 64'(bus.rddata), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_release_wrrdy", 64'(bus.wrrdy), 64'd1);
        bus.rdrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_no_stale", 64'(bus.rdvld), 64'd0);
        end
        do_read(4'd3, 0);
        do_read(4'd7, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
